// File: rtl/npu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : npu_pkg
// Brief    : Shared constants for the NPU vector engine: default sizing and
//            FSM state encodings.
// Revision : 1.0 - initial release
// ============================================================================
package npu_pkg;

  // Default sizing of the engine
  localparam int c_DEF_LANES      = 4;
  localparam int c_DEF_DW         = 8;
  localparam int c_DEF_ACCW       = 24;
  localparam int c_DEF_FIFO_DEPTH = 8;

  // FSM state encodings (STATE_DEBUG exposes these zero-extended to 4 bits)
  localparam logic [2:0] c_ST_IDLE = 3'd0;
  localparam logic [2:0] c_ST_ACC  = 3'd1;
  localparam logic [2:0] c_ST_POST = 3'd2;
  localparam logic [2:0] c_ST_PUSH = 3'd3;
  localparam logic [2:0] c_ST_FIN  = 3'd4;

endpackage
`default_nettype wire

// File: rtl/npu_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module   : npu_sync_fifo
// Brief    : Single-clock first-word-fall-through FIFO. Full/empty come from
//            an occupancy count one bit wider than the pointers. Pushes while
//            full and pops while empty are dropped internally.
// Revision : 1.0 - initial release
// ============================================================================
module npu_sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_wdata,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty
);

  localparam int c_AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [c_AW-1:0]  r_wr_ptr;
  logic [c_AW-1:0]  r_rd_ptr;
  logic [c_AW:0]    r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_count == (c_AW+1)'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;

  // Head word falls through; forced to zero when nothing is stored
  assign o_rdata = o_empty ? '0 : r_mem[r_rd_ptr];

  // Storage array, written only on an accepted push
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_wdata;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + c_AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + c_AW'(1);
    end
  end

  // Occupancy count; simultaneous push and pop leaves it unchanged
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else begin
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + (c_AW+1)'(1);
        2'b01:   r_count <= r_count - (c_AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/npu_vec_engine.sv
`default_nettype none
// ============================================================================
// Module   : npu_vec_engine
// Brief    : Multi-lane signed MAC engine. Accumulates LEN beats of
//            data*weight per lane, then adds bias, applies optional ReLU,
//            arithmetic right shift and saturation, and queues the result
//            vector in an output FIFO.
// Revision : 1.0 - initial release
// ============================================================================
module npu_vec_engine
  import npu_pkg::*;
#(
  parameter int LANES      = c_DEF_LANES,
  parameter int DW         = c_DEF_DW,
  parameter int ACCW       = c_DEF_ACCW,
  parameter int FIFO_DEPTH = c_DEF_FIFO_DEPTH
) (
  input  logic                CLKEXT,
  input  logic                RST_GLO,
  input  logic                START,
  input  logic [7:0]          LEN,
  input  logic [3:0]          MODE,
  input  logic [DW-1:0]       BIAS_IN,
  input  logic                IN_VALID,
  output logic                IN_READY,
  input  logic [LANES*DW-1:0] D_IN,
  input  logic [LANES*DW-1:0] W_IN,
  output logic                OUT_VALID,
  input  logic                OUT_READY,
  output logic [LANES*DW-1:0] D_OUT,
  output logic                FIFO_FULL,
  output logic                FIFO_EMPTY,
  output logic                BUSY,
  output logic                DONE,
  output logic [3:0]          STATE_DEBUG
);

  logic [2:0]          r_state;
  logic [2:0]          w_state_nxt;
  logic [7:0]          r_len;
  logic [7:0]          r_cnt;
  logic [3:0]          r_mode;
  logic [DW-1:0]       r_bias;
  logic [LANES*DW-1:0] r_res;
  logic [LANES*DW-1:0] w_post;
  logic                w_start;
  logic                w_beat;
  logic                w_last_beat;
  logic                w_push;
  logic                w_full;
  logic                w_empty;

  // START is only honoured from IDLE
  assign w_start     = START && (r_state == c_ST_IDLE);
  assign IN_READY    = (r_state == c_ST_ACC);
  assign w_beat      = IN_VALID && IN_READY;
  assign w_last_beat = w_beat && ((r_cnt + 8'd1) == r_len);
  // Never push into a full FIFO; a same-cycle pop does not free the slot yet
  assign w_push      = (r_state == c_ST_PUSH) && !w_full;

  assign BUSY        = (r_state != c_ST_IDLE);
  assign DONE        = (r_state == c_ST_FIN);
  assign STATE_DEBUG = {1'b0, r_state};
  assign OUT_VALID   = !w_empty;
  assign FIFO_FULL   = w_full;
  assign FIFO_EMPTY  = w_empty;

  // Next-state decode for the job sequencer
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_ST_IDLE: if (START) w_state_nxt = (LEN == 8'd0) ? c_ST_POST : c_ST_ACC;
      c_ST_ACC:  if (w_last_beat) w_state_nxt = c_ST_POST;
      c_ST_POST: w_state_nxt = c_ST_PUSH;
      c_ST_PUSH: if (!w_full) w_state_nxt = c_ST_FIN;
      c_ST_FIN:  w_state_nxt = c_ST_IDLE;
      default:   w_state_nxt = c_ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge CLKEXT or posedge RST_GLO) begin
    if (RST_GLO) r_state <= c_ST_IDLE;
    else         r_state <= w_state_nxt;
  end

  // Job configuration latch and beat counter
  always_ff @(posedge CLKEXT or posedge RST_GLO) begin
    if (RST_GLO) begin
      r_len  <= '0;
      r_mode <= '0;
      r_bias <= '0;
      r_cnt  <= '0;
    end else if (w_start) begin
      r_len  <= LEN;
      r_mode <= MODE;
      r_bias <= BIAS_IN;
      r_cnt  <= '0;
    end else if (w_beat) begin
      r_cnt  <= r_cnt + 8'd1;
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic signed [ACCW-1:0] r_acc;
    logic signed [2*DW-1:0] w_d;
    logic signed [2*DW-1:0] w_w;
    logic signed [2*DW-1:0] w_prod;
    logic signed [ACCW-1:0] w_sum;
    logic signed [ACCW-1:0] w_relu;
    logic signed [ACCW-1:0] w_shift;
    logic [ACCW-DW:0]       w_upper;
    logic [DW-1:0]          w_sat;

    // Operands widened to the full product width so the product is exact
    assign w_d    = {{DW{D_IN[i*DW+DW-1]}}, D_IN[i*DW +: DW]};
    assign w_w    = {{DW{W_IN[i*DW+DW-1]}}, W_IN[i*DW +: DW]};
    assign w_prod = w_d * w_w;

    // Per-lane accumulator, cleared at job start, wraps modulo 2^ACCW
    always_ff @(posedge CLKEXT or posedge RST_GLO) begin
      if (RST_GLO)     r_acc <= '0;
      else if (w_start) r_acc <= '0;
      else if (w_beat)  r_acc <= r_acc + {{(ACCW-2*DW){w_prod[2*DW-1]}}, w_prod};
    end

    assign w_sum   = r_acc + {{(ACCW-DW){r_bias[DW-1]}}, r_bias};
    assign w_relu  = (r_mode[0] && w_sum[ACCW-1]) ? '0 : w_sum;
    assign w_shift = w_relu >>> r_mode[3:1];
    // In range iff every bit from the DW-1 sign position upward agrees
    assign w_upper = w_shift[ACCW-1:DW-1];

    // Saturate the shifted value to the signed DW range
    always_comb begin
      w_sat = w_shift[DW-1:0];
      if (!((&w_upper) || !(|w_upper))) begin
        w_sat = w_shift[ACCW-1] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
      end
    end

    assign w_post[i*DW +: DW] = w_sat;
  end

  // Result register, loaded during the single POST cycle
  always_ff @(posedge CLKEXT or posedge RST_GLO) begin
    if (RST_GLO)                  r_res <= '0;
    else if (r_state == c_ST_POST) r_res <= w_post;
  end

  npu_sync_fifo #(
    .WIDTH (LANES*DW),
    .DEPTH (FIFO_DEPTH)
  ) u_out_fifo (
    .clk     (CLKEXT),
    .rst     (RST_GLO),
    .i_push  (w_push),
    .i_pop   (OUT_READY),
    .i_wdata (r_res),
    .o_rdata (D_OUT),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

endmodule
`default_nettype wire

// File: tb/tb_npu_vec_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_npu_vec_engine
// Brief    : Directed self-checking bench for npu_vec_engine (4 lanes, 8 bit).
// Revision : 1.0 - initial release
// ============================================================================
module tb_npu_vec_engine;

  logic        CLKEXT = 1'b0;
  logic        RST_GLO = 1'b1;
  logic        START = 1'b0;
  logic [7:0]  LEN = '0;
  logic [3:0]  MODE = '0;
  logic [7:0]  BIAS_IN = '0;
  logic        IN_VALID = 1'b0;
  logic        IN_READY;
  logic [31:0] D_IN = '0;
  logic [31:0] W_IN = '0;
  logic        OUT_VALID;
  logic        OUT_READY = 1'b0;
  logic [31:0] D_OUT;
  logic        FIFO_FULL, FIFO_EMPTY, BUSY, DONE;
  logic [3:0]  STATE_DEBUG;

  int checks = 0;
  int failures = 0;

  logic [3:0] st_log[$];
  int         done_cnt;
  bit         in_ready_seen;

  npu_vec_engine #(.LANES(4), .DW(8), .ACCW(24), .FIFO_DEPTH(8)) dut (
    .CLKEXT(CLKEXT), .RST_GLO(RST_GLO), .START(START), .LEN(LEN), .MODE(MODE),
    .BIAS_IN(BIAS_IN), .IN_VALID(IN_VALID), .IN_READY(IN_READY), .D_IN(D_IN),
    .W_IN(W_IN), .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .D_OUT(D_OUT),
    .FIFO_FULL(FIFO_FULL), .FIFO_EMPTY(FIFO_EMPTY), .BUSY(BUSY), .DONE(DONE),
    .STATE_DEBUG(STATE_DEBUG)
  );

  always #5 CLKEXT = ~CLKEXT;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] pack4(input logic [7:0] a, input logic [7:0] b,
                                        input logic [7:0] c, input logic [7:0] d);
    return {d, c, b, a};
  endfunction

  function automatic logic [31:0] rep4(input logic [7:0] a);
    return {a, a, a, a};
  endfunction

  // Observation at the falling edge: state transitions, DONE pulses, IN_READY
  task automatic tick();
    @(negedge CLKEXT);
    if (STATE_DEBUG !== st_log[$]) st_log.push_back(STATE_DEBUG);
    if (DONE === 1'b1) done_cnt++;
    if (IN_READY === 1'b1) in_ready_seen = 1'b1;
  endtask

  task automatic start_job(input logic [7:0] len, input logic [3:0] mode, input logic [7:0] bias);
    st_log.delete();
    st_log.push_back(STATE_DEBUG);
    done_cnt = 0;
    in_ready_seen = 1'b0;
    START = 1'b1; LEN = len; MODE = mode; BIAS_IN = bias;
    tick();
    START = 1'b0;
  endtask

  // One input beat; glitch also fires a conflicting START during the beat
  task automatic send_beat(input logic [31:0] d, input logic [31:0] w, input bit glitch);
    IN_VALID = 1'b1; D_IN = d; W_IN = w;
    if (glitch) begin
      START = 1'b1; LEN = 8'd1; BIAS_IN = 8'd99;
    end
    tick();
    IN_VALID = 1'b0; START = 1'b0;
  endtask

  task automatic wait_idle(input int max_cycles);
    for (int k = 0; k < max_cycles && STATE_DEBUG !== 4'd0; k++) tick();
  endtask

  task automatic run_job(input logic [7:0] len, input logic [3:0] mode, input logic [7:0] bias,
                         input logic [31:0] d, input logic [31:0] w);
    start_job(len, mode, bias);
    for (int b = 0; b < int'(len); b++) send_beat(d, w, 1'b0);
    wait_idle(30);
  endtask

  task automatic pop_word(output logic [31:0] vec, output bit ok);
    ok  = (OUT_VALID === 1'b1);
    vec = D_OUT;
    if (ok) begin
      OUT_READY = 1'b1;
      tick();
      OUT_READY = 1'b0;
    end
  endtask

  task automatic test_reset();
    tick(); tick();
    checks++; if (IN_READY !== 1'b0)     begin failures++; $display("FAIL reset_in_ready got=%b want=0", IN_READY); end
    checks++; if (OUT_VALID !== 1'b0)    begin failures++; $display("FAIL reset_out_valid got=%b want=0", OUT_VALID); end
    checks++; if (FIFO_EMPTY !== 1'b1)   begin failures++; $display("FAIL reset_fifo_empty got=%b want=1", FIFO_EMPTY); end
    checks++; if (FIFO_FULL !== 1'b0)    begin failures++; $display("FAIL reset_fifo_full got=%b want=0", FIFO_FULL); end
    checks++; if (BUSY !== 1'b0)         begin failures++; $display("FAIL reset_busy got=%b want=0", BUSY); end
    checks++; if (DONE !== 1'b0)         begin failures++; $display("FAIL reset_done got=%b want=0", DONE); end
    checks++; if (STATE_DEBUG !== 4'd0)  begin failures++; $display("FAIL reset_state got=%0d want=0", STATE_DEBUG); end
    checks++; if (D_OUT !== 32'd0)       begin failures++; $display("FAIL reset_d_out got=%h want=0", D_OUT); end
    RST_GLO = 1'b0;
    tick();
  endtask

  // Two beats of D={2,4,6,8}, W=2, bias 1: lane = 2*(2*d)+1 -> {9,17,25,33}
  task automatic test_basic();
    logic [31:0] v; bit ok; bit seq_ok;
    logic [3:0] exp_seq [6];
    exp_seq = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd0};
    run_job(8'd2, 4'd0, 8'd1, pack4(8'd2, 8'd4, 8'd6, 8'd8), rep4(8'd2));
    seq_ok = (st_log.size() == 6);
    for (int k = 0; k < 6 && seq_ok; k++) seq_ok = (st_log[k] === exp_seq[k]);
    checks++; if (!seq_ok)       begin failures++; $display("FAIL basic_state_seq got_len=%0d want=0,1,2,3,4,0", st_log.size()); end
    checks++; if (done_cnt != 1) begin failures++; $display("FAIL basic_done_count got=%0d want=1", done_cnt); end
    pop_word(v, ok);
    checks++; if (!ok || v !== pack4(8'd9, 8'd17, 8'd25, 8'd33))
      begin failures++; $display("FAIL basic_result got=%h valid=%0d want=%h", v, ok, pack4(8'd9, 8'd17, 8'd25, 8'd33)); end
    checks++; if (FIFO_EMPTY !== 1'b1) begin failures++; $display("FAIL basic_empty_after_pop got=%b want=1", FIFO_EMPTY); end
  endtask

  task automatic test_saturation();
    logic [31:0] v; bit ok;
    run_job(8'd1, 4'd0, 8'd0, rep4(8'd127), rep4(8'd127));
    pop_word(v, ok);
    checks++; if (!ok || v !== rep4(8'h7F)) begin failures++; $display("FAIL sat_pos got=%h want=%h", v, rep4(8'h7F)); end
    run_job(8'd1, 4'd0, 8'd0, rep4(8'h80), rep4(8'd127));
    pop_word(v, ok);
    checks++; if (!ok || v !== rep4(8'h80)) begin failures++; $display("FAIL sat_neg got=%h want=%h", v, rep4(8'h80)); end
  endtask

  task automatic test_relu_shift();
    logic [31:0] v; bit ok;
    run_job(8'd1, 4'b0001, 8'd0, rep4(8'hFD), rep4(8'd2));
    pop_word(v, ok);
    checks++; if (!ok || v !== rep4(8'h00)) begin failures++; $display("FAIL relu_on got=%h want=%h", v, rep4(8'h00)); end
    run_job(8'd1, 4'b0000, 8'd0, rep4(8'hFD), rep4(8'd2));
    pop_word(v, ok);
    checks++; if (!ok || v !== rep4(8'hFA)) begin failures++; $display("FAIL relu_off got=%h want=%h", v, rep4(8'hFA)); end
    run_job(8'd1, 4'b0010, 8'd0, rep4(8'hFD), rep4(8'd2));
    pop_word(v, ok);
    checks++; if (!ok || v !== rep4(8'hFD)) begin failures++; $display("FAIL shift1_neg got=%h want=%h", v, rep4(8'hFD)); end
    run_job(8'd1, 4'b0100, 8'd0, rep4(8'd17), rep4(8'd1));
    pop_word(v, ok);
    checks++; if (!ok || v !== rep4(8'd4)) begin failures++; $display("FAIL shift2_pos got=%h want=%h", v, rep4(8'd4)); end
  endtask

  task automatic test_len_zero();
    logic [31:0] v; bit ok;
    run_job(8'd0, 4'd0, 8'd5, rep4(8'd0), rep4(8'd0));
    checks++; if (in_ready_seen) begin failures++; $display("FAIL len0_in_ready got=1 want=0"); end
    checks++; if (done_cnt != 1) begin failures++; $display("FAIL len0_done got=%0d want=1", done_cnt); end
    pop_word(v, ok);
    checks++; if (!ok || v !== rep4(8'd5)) begin failures++; $display("FAIL len0_result got=%h want=%h", v, rep4(8'd5)); end
  endtask

  // A second START during ACC (LEN=1, bias=99) must not disturb the job: 2*(1*3)=6
  task automatic test_start_ignored();
    logic [31:0] v; bit ok;
    start_job(8'd2, 4'd0, 8'd0);
    send_beat(rep4(8'd1), rep4(8'd3), 1'b1);
    send_beat(rep4(8'd1), rep4(8'd3), 1'b0);
    wait_idle(30);
    checks++; if (done_cnt != 1) begin failures++; $display("FAIL start_ign_done got=%0d want=1", done_cnt); end
    pop_word(v, ok);
    checks++; if (!ok || v !== rep4(8'd6)) begin failures++; $display("FAIL start_ign_result got=%h want=%h", v, rep4(8'd6)); end
  endtask

  task automatic test_fifo_full();
    logic [31:0] v; bit ok;
    OUT_READY = 1'b0;
    for (int j = 1; j <= 8; j++) begin
      run_job(8'd1, 4'd0, 8'd0, rep4(8'(j)), rep4(8'd1));
      if (j == 7) begin
        checks++; if (FIFO_FULL !== 1'b0) begin failures++; $display("FAIL full_after7 got=%b want=0", FIFO_FULL); end
      end
    end
    checks++; if (FIFO_FULL !== 1'b1) begin failures++; $display("FAIL full_after8 got=%b want=1", FIFO_FULL); end
    start_job(8'd1, 4'd0, 8'd0);
    send_beat(rep4(8'd9), rep4(8'd1), 1'b0);
    wait_idle(10);
    checks++; if (STATE_DEBUG !== 4'd3) begin failures++; $display("FAIL full_hold_state got=%0d want=3", STATE_DEBUG); end
    checks++; if (BUSY !== 1'b1)        begin failures++; $display("FAIL full_hold_busy got=%b want=1", BUSY); end
    checks++; if (done_cnt != 0)        begin failures++; $display("FAIL full_hold_done got=%0d want=0", done_cnt); end
    checks++; if (D_OUT !== rep4(8'd1)) begin failures++; $display("FAIL full_head got=%h want=%h", D_OUT, rep4(8'd1)); end
    OUT_READY = 1'b1;
    tick();
    OUT_READY = 1'b0;
    wait_idle(10);
    checks++; if (done_cnt != 1)        begin failures++; $display("FAIL full_release_done got=%0d want=1", done_cnt); end
    checks++; if (STATE_DEBUG !== 4'd0) begin failures++; $display("FAIL full_release_state got=%0d want=0", STATE_DEBUG); end
    checks++; if (FIFO_FULL !== 1'b1)   begin failures++; $display("FAIL full_refilled got=%b want=1", FIFO_FULL); end
    for (int j = 2; j <= 9; j++) begin
      pop_word(v, ok);
      checks++; if (!ok || v !== rep4(8'(j))) begin failures++; $display("FAIL full_drain_%0d got=%h want=%h", j, v, rep4(8'(j))); end
    end
    checks++; if (FIFO_EMPTY !== 1'b1) begin failures++; $display("FAIL full_drained_empty got=%b want=1", FIFO_EMPTY); end
  endtask

  task automatic test_reset_midjob();
    logic [31:0] v; bit ok;
    OUT_READY = 1'b0;
    run_job(8'd1, 4'd0, 8'd0, rep4(8'd1), rep4(8'd1));
    run_job(8'd1, 4'd0, 8'd0, rep4(8'd2), rep4(8'd1));
    checks++; if (FIFO_EMPTY !== 1'b0) begin failures++; $display("FAIL mid_prefill got=%b want=0", FIFO_EMPTY); end
    start_job(8'd3, 4'd0, 8'd0);
    send_beat(rep4(8'd2), rep4(8'd2), 1'b0);
    RST_GLO = 1'b1;
    #1;
    checks++; if (IN_READY !== 1'b0)    begin failures++; $display("FAIL mid_in_ready got=%b want=0", IN_READY); end
    checks++; if (OUT_VALID !== 1'b0)   begin failures++; $display("FAIL mid_out_valid got=%b want=0", OUT_VALID); end
    checks++; if (FIFO_EMPTY !== 1'b1)  begin failures++; $display("FAIL mid_fifo_empty got=%b want=1", FIFO_EMPTY); end
    checks++; if (FIFO_FULL !== 1'b0)   begin failures++; $display("FAIL mid_fifo_full got=%b want=0", FIFO_FULL); end
    checks++; if (BUSY !== 1'b0)        begin failures++; $display("FAIL mid_busy got=%b want=0", BUSY); end
    checks++; if (DONE !== 1'b0)        begin failures++; $display("FAIL mid_done got=%b want=0", DONE); end
    checks++; if (STATE_DEBUG !== 4'd0) begin failures++; $display("FAIL mid_state got=%0d want=0", STATE_DEBUG); end
    checks++; if (D_OUT !== 32'd0)      begin failures++; $display("FAIL mid_d_out got=%h want=0", D_OUT); end
    done_cnt = 0;
    tick();
    RST_GLO = 1'b0;
    for (int k = 0; k < 5; k++) tick();
    checks++; if (done_cnt != 0) begin failures++; $display("FAIL mid_no_done got=%0d want=0", done_cnt); end
    run_job(8'd1, 4'd0, 8'd0, rep4(8'd5), rep4(8'd3));
    checks++; if (done_cnt != 1) begin failures++; $display("FAIL mid_fresh_done got=%0d want=1", done_cnt); end
    pop_word(v, ok);
    checks++; if (!ok || v !== rep4(8'd15)) begin failures++; $display("FAIL mid_fresh_result got=%h want=%h", v, rep4(8'd15)); end
    checks++; if (FIFO_EMPTY !== 1'b1) begin failures++; $display("FAIL mid_fresh_empty got=%b want=1", FIFO_EMPTY); end
  endtask

  initial begin
    st_log.push_back(4'd0);
    done_cnt = 0;
    in_ready_seen = 1'b0;
    test_reset();
    test_basic();
    test_saturation();
    test_relu_shift();
    test_len_zero();
    test_start_ignored();
    test_fifo_full();
    test_reset_midjob();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
